cw_sample_buffer: RTL and testbench

Capture-memory stage directly downstream of the ChipWatcher trigger core. Consumes the core's write strobe (`wt_ce`, `wt_en`, `wt_addr`) together with the probed node data (`non_bus_din`, `bus_din`), and stores samples into a circular on-chip RAM. After capture ends, it streams the samples oldest-first over a valid/ready read port to the readout serializer. Single clock domain (`trig_clk`); any clock-domain crossing toward JTAG happens in the serializer.

---
 rtl/cw_buf_pkg.sv | 16 +
 rtl/cw_sample_ram.sv | 22 ++
 rtl/cw_sample_buffer.sv | 174 +++++++++++++++++
 tb/tb_cw_sample_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cw_buf_pkg.sv
// Shared types and helpers for the ChipWatcher capture buffer.
package cw_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2,
    ST_READOUT = 2'd3
  } buf_state_e;

  function automatic int unsigned word_width(input int unsigned non_bus_w,
                                             input int unsigned bus_w);
    return non_bus_w + bus_w;
  endfunction

endpackage

// File: rtl/cw_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port, no reset.
module cw_sample_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [0:(1 << ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cw_sample_buffer.sv
// Circular capture memory behind the ChipWatcher trigger core; replays
// captured samples oldest-first over a valid/ready port.
module cw_sample_buffer
  import cw_buf_pkg::*;
#(
  parameter int unsigned NON_BUS_W = 7,
  parameter int unsigned BUS_W     = 25,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic                       trig_clk,
  input  logic                       jrstn,
  input  logic                       wt_ce,
  input  logic                       wt_en,
  input  logic [15:0]                wt_addr,
  input  logic [NON_BUS_W-1:0]       non_bus_din,
  input  logic [BUS_W-1:0]           bus_din,
  input  logic                       rd_start,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [NON_BUS_W+BUS_W-1:0] rd_data,
  output logic                       rd_last,
  output logic [1:0]                 buf_state,
  output logic [ADDR_W:0]            cap_count,
  output logic                       wrapped,
  output logic                       overrun
);

  localparam int unsigned      WORD_W    = word_width(NON_BUS_W, BUS_W);
  localparam logic [ADDR_W:0]  DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  buf_state_e state_q, state_d;

  logic              ce_q;
  logic              wr_pend_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [WORD_W-1:0] wr_data_q;
  logic [ADDR_W-1:0] first_addr_q, last_addr_q;
  logic [ADDR_W:0]   cap_count_q;
  logic              wrapped_q, overrun_q;

  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W:0]   issue_left_q;
  logic              rd_pend_q, pend_last_q;
  logic [WORD_W-1:0] ram_rdata;

  logic [WORD_W-1:0] fifo_data_q [2];
  logic              fifo_last_q [2];
  logic              fifo_head_q;
  logic [1:0]        fifo_cnt_q;

  logic ce_rise, ce_fall, strobe, wr_accept, arm, load_rd, issue, pop, pop_last;
  logic [1:0] occ_after;
  logic       fifo_wr_idx;
  logic       unused_addr_hi;

  assign unused_addr_hi = ^wt_addr[15:ADDR_W];

  assign ce_rise   = wt_ce & ~ce_q;
  assign ce_fall   = ~wt_ce & ce_q;
  assign strobe    = wt_ce & wt_en;
  assign wr_accept = (state_q == ST_CAPTURE) & strobe;
  assign arm       = ce_rise & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign load_rd   = (state_q == ST_DONE) & ~ce_rise & rd_start & (cap_count_q != '0);

  assign rd_valid  = (fifo_cnt_q != 2'd0);
  assign pop       = rd_valid & rd_ready;
  assign pop_last  = pop & fifo_last_q[fifo_head_q];

  // A read may only be launched if its word is sure to find a free FIFO slot
  // one cycle later, counting the read already in flight.
  assign occ_after   = fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
  assign issue       = (state_q == ST_READOUT) & (issue_left_q != '0) & (occ_after < 2'd2);
  assign fifo_wr_idx = fifo_head_q ^ fifo_cnt_q[0];

  assign rd_data   = rd_valid ? fifo_data_q[fifo_head_q] : '0;
  assign rd_last   = rd_valid & fifo_last_q[fifo_head_q];
  assign buf_state = state_q;
  assign cap_count = cap_count_q;
  assign wrapped   = wrapped_q;
  assign overrun   = overrun_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (ce_rise) state_d = ST_CAPTURE;
      ST_CAPTURE: if (ce_fall) state_d = ST_DONE;
      ST_DONE: begin
        if (ce_rise)       state_d = ST_CAPTURE;
        else if (rd_start) state_d = (cap_count_q == '0) ? ST_IDLE : ST_READOUT;
      end
      ST_READOUT: if (pop_last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge trig_clk) begin
    if (!jrstn) begin
      state_q      <= ST_IDLE;
      ce_q         <= 1'b0;
      wr_pend_q    <= 1'b0;
      first_addr_q <= '0;
      last_addr_q  <= '0;
      cap_count_q  <= '0;
      wrapped_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ce_q      <= wt_ce;
      wr_pend_q <= wr_accept;
      if (arm) begin
        cap_count_q <= '0;
        wrapped_q   <= 1'b0;
        overrun_q   <= 1'b0;
      end else if (wr_accept) begin
        if (cap_count_q == '0) first_addr_q <= wt_addr[ADDR_W-1:0];
        last_addr_q <= wt_addr[ADDR_W-1:0];
        if (cap_count_q == DEPTH_CNT) wrapped_q <= 1'b1;
        else                          cap_count_q <= cap_count_q + CNT_ONE;
      end
      if ((state_q == ST_READOUT) && strobe) overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge trig_clk) begin
    wr_addr_q <= wt_addr[ADDR_W-1:0];
    wr_data_q <= {bus_din, non_bus_din};
  end

  always_ff @(posedge trig_clk) begin
    if (!jrstn) begin
      rd_addr_q    <= '0;
      issue_left_q <= '0;
      rd_pend_q    <= 1'b0;
      pend_last_q  <= 1'b0;
      fifo_head_q  <= 1'b0;
      fifo_cnt_q   <= 2'd0;
    end else begin
      if (load_rd) begin
        rd_addr_q    <= wrapped_q ? last_addr_q + ADDR_ONE : first_addr_q;
        issue_left_q <= cap_count_q;
      end else if (issue) begin
        rd_addr_q    <= rd_addr_q + ADDR_ONE;
        issue_left_q <= issue_left_q - CNT_ONE;
      end
      rd_pend_q   <= issue;
      pend_last_q <= (issue_left_q == CNT_ONE);
      if (pop) fifo_head_q <= ~fifo_head_q;
      fifo_cnt_q <= occ_after;
    end
  end

  always_ff @(posedge trig_clk) begin
    if (rd_pend_q) begin
      fifo_data_q[fifo_wr_idx] <= ram_rdata;
      fifo_last_q[fifo_wr_idx] <= pend_last_q;
    end
  end

  cw_sample_ram #(
    .ADDR_W(ADDR_W),
    .WORD_W(WORD_W)
  ) u_ram (
    .clk     (trig_clk),
    .wr_en   (wr_pend_q),
    .wr_addr (wr_addr_q),
    .wr_data (wr_data_q),
    .rd_en   (issue),
    .rd_addr (rd_addr_q),
    .rd_data (ram_rdata)
  );

endmodule

// File: tb/tb_cw_sample_buffer.sv
// Randomized bench for cw_sample_buffer against a queue-based capture/readout model.
module tb_cw_sample_buffer;

  localparam int unsigned NB_W  = 7;
  localparam int unsigned B_W   = 25;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned WW    = 32;

  logic          trig_clk = 1'b0;
  logic          jrstn = 1'b0;
  logic          wt_ce = 1'b0, wt_en = 1'b0;
  logic [15:0]   wt_addr = '0;
  logic [NB_W-1:0] non_bus_din = '0;
  logic [B_W-1:0]  bus_din = '0;
  logic          rd_start = 1'b0, rd_ready = 1'b0;
  logic          rd_valid, rd_last, wrapped, overrun;
  logic [WW-1:0] rd_data;
  logic [1:0]    buf_state;
  logic [AW:0]   cap_count;

  cw_sample_buffer #(.NON_BUS_W(NB_W), .BUS_W(B_W), .ADDR_W(AW)) dut (
    .trig_clk(trig_clk), .jrstn(jrstn), .wt_ce(wt_ce), .wt_en(wt_en), .wt_addr(wt_addr),
    .non_bus_din(non_bus_din), .bus_din(bus_din), .rd_start(rd_start), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .buf_state(buf_state),
    .cap_count(cap_count), .wrapped(wrapped), .overrun(overrun)
  );

  always #5 trig_clk = ~trig_clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, longint unsigned act, longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: every accepted write is appended to a list; a readout
  // must return the newest min(N, DEPTH) of them, oldest first.
  int            m_state = 0;
  bit            m_ce_prev = 0;
  int            m_overrun = 0;
  bit            hs_last_seen = 0;
  logic [WW-1:0] m_written[$];
  logic [WW-1:0] m_exp[$];
  logic [WW-1:0] rx_log[$];

  function automatic int m_cap();
    return (m_written.size() > DEPTH) ? DEPTH : m_written.size();
  endfunction

  function automatic int m_wrapped();
    return (m_written.size() > DEPTH) ? 1 : 0;
  endfunction

  always @(posedge trig_clk) begin
    bit rise, fall, wr;
    rise = wt_ce && !m_ce_prev;
    fall = !wt_ce && m_ce_prev;
    wr   = wt_ce && wt_en;
    if (!jrstn) begin
      m_state = 0; m_ce_prev = 0; m_overrun = 0;
      m_written.delete(); m_exp.delete();
    end else begin
      case (m_state)
        0: if (rise) begin m_state = 1; m_written.delete(); m_overrun = 0; end
        1: begin
          if (wr) m_written.push_back({bus_din, non_bus_din});
          if (fall) m_state = 2;
        end
        2: if (rise) begin
          m_state = 1; m_written.delete(); m_overrun = 0;
        end else if (rd_start) begin
          if (m_written.size() == 0) m_state = 0;
          else begin
            m_exp.delete();
            for (int i = m_written.size() - m_cap(); i < m_written.size(); i++)
              m_exp.push_back(m_written[i]);
            m_state = 3;
          end
        end
        default: begin
          if (wr) m_overrun = 1;
          if (hs_last_seen) m_state = 0;
        end
      endcase
      m_ce_prev = wt_ce;
    end
    hs_last_seen = 0;
  end

  bit            stall_prev = 0;
  logic [WW-1:0] stall_data = '0;
  logic          stall_last = 1'b0;

  always @(negedge trig_clk) begin
    check("buf_state", buf_state, m_state);
    check("cap_count", cap_count, m_cap());
    check("wrapped", wrapped, m_wrapped());
    check("overrun", overrun, m_overrun);
    check("valid_outside_readout", rd_valid && (m_state != 3 || m_exp.size() == 0), 0);
    if (stall_prev) begin
      check("stall_valid", rd_valid, 1);
      check("stall_data", rd_data, stall_data);
      check("stall_last", rd_last, stall_last);
    end
    if (rd_valid && rd_ready && m_state == 3 && m_exp.size() != 0) begin
      check("rd_data", rd_data, m_exp[0]);
      check("rd_last", rd_last, (m_exp.size() == 1) ? 1 : 0);
      rx_log.push_back(rd_data);
      if (m_exp.size() == 1) hs_last_seen = 1;
      void'(m_exp.pop_front());
    end
    stall_prev = rd_valid && !rd_ready && jrstn;
    stall_data = rd_data;
    stall_last = rd_last;
  end

  task automatic tick();
    @(posedge trig_clk);
    #1;
  endtask

  function automatic logic [WW-1:0] gen_word(int mode, int i);
    case (mode)
      1:       return WW'(i);
      2:       return WW'(32'h11 + i);
      default: return WW'($urandom());
    endcase
  endfunction

  // Arm, perform n sequential-address writes, then drop wt_ce.
  task automatic capture(int n, logic [15:0] base, int dmode, bit gaps);
    wt_ce = 1'b1; wt_en = 1'b0; tick();
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        wt_en = 1'b0; rd_start = ($urandom_range(0, 3) == 0); tick();
      end
      wt_en = 1'b1;
      wt_addr = base + 16'(i);
      {bus_din, non_bus_din} = gen_word(dmode, i);
      rd_start = gaps && ($urandom_range(0, 3) == 0);
      tick();
    end
    wt_en = 1'b0; wt_ce = 1'b0; rd_start = 1'b0; tick();
  endtask

  // ready_mode: 0 always ready, 1 toggling, 2 random.
  task automatic readout(int ready_mode, bit inject, bit chk_tput);
    int exp_n, cyc, first_lat;
    exp_n = m_cap();
    first_lat = -1;
    cyc = 0;
    rx_log.delete();
    rd_start = 1'b1; rd_ready = 1'b1; tick(); rd_start = 1'b0;
    while (m_state == 3 && cyc < 500) begin
      if (first_lat < 0 && rd_valid) first_lat = cyc;
      case (ready_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc % 2 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      wt_ce = inject && (cyc == 1 || $urandom_range(0, 7) == 0);
      wt_en = wt_ce;
      rd_start = ($urandom_range(0, 5) == 0);
      tick();
      cyc++;
    end
    wt_ce = 1'b0; wt_en = 1'b0; rd_ready = 1'b0; rd_start = 1'b0;
    if (exp_n > 0) begin
      check("readout_finished", (cyc < 500) ? 1 : 0, 1);
      check("first_valid_latency", first_lat, 2);
      check("words_received", rx_log.size(), exp_n);
      if (chk_tput) check("throughput_cycles", cyc, exp_n + 2);
    end
    if (cyc >= 500) begin
      jrstn = 1'b0; tick(); jrstn = 1'b1;
    end
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    jrstn = 1'b1;
    check("reset_valid", rd_valid, 0);
    check("reset_state", buf_state, 0);
    check("reset_cap", cap_count, 0);
    check("reset_wrapped", wrapped, 0);
    check("reset_overrun", overrun, 0);
    tick();

    // five sequential words, no wrap
    capture(5, 16'h0000, 2, 0);
    check("t1_done_state", buf_state, 2);
    readout(1, 0, 0);
    check("t1_cap", cap_count, 5);
    check("t1_wrapped", wrapped, 0);
    for (int i = 0; i < 5; i++) check("t1_word", rx_log[i], 32'h11 + i);

    // 20 writes into a 16-deep buffer
    capture(20, 16'h0000, 1, 0);
    readout(0, 0, 1);
    check("t2_cap", cap_count, 16);
    check("t2_wrapped", wrapped, 1);
    check("t2_count", rx_log.size(), 16);
    for (int i = 0; i < 16; i++) check("t2_word", rx_log[i], 4 + i);

    // eight words under toggling ready
    capture(8, 16'h0123, 0, 1);
    readout(1, 0, 0);
    check("t3_count", rx_log.size(), 8);

    // write strobes during readout
    capture(6, 16'h0040, 0, 0);
    readout(2, 1, 0);
    check("t4_overrun", overrun, 1);
    check("t4_cap", cap_count, 6);

    // reset while the third word is presented
    capture(10, 16'h0007, 1, 0);
    rd_start = 1'b1; rd_ready = 1'b1; tick(); rd_start = 1'b0;
    repeat (4) tick();
    check("t5_third_valid", rd_valid, 1);
    check("t5_third_word", rd_data, 2);
    jrstn = 1'b0; tick(); jrstn = 1'b1;
    rd_ready = 1'b0;
    check("t5_valid", rd_valid, 0);
    check("t5_state", buf_state, 0);
    check("t5_cap", cap_count, 0);
    tick();

    // arm/disarm with no writes
    capture(0, 16'h0000, 0, 0);
    check("t6_done", buf_state, 2);
    readout(0, 0, 0);
    check("t6_idle", buf_state, 0);
    repeat (3) tick();

    for (int it = 0; it < 30; it++) begin
      capture($urandom_range(0, 40), 16'($urandom()), 0, 1'($urandom_range(0, 1)));
      readout($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
      rd_start = 1'b1; tick(); rd_start = 1'b0; tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
